// File: rtl/cell_config_loader.sv
// Loads a chromosome of 4-bit configuration words into an array of cells, one cell at a time.
// Every strobe and the cell reset come straight from flops, so the cells' edge-sensitive write inputs never see glitches.
module cell_config_loader #(
    parameter int NUM_CELLS = 16,
    parameter int IDX_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [3:0]           cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [3:0]           set_ram,
    output logic [NUM_CELLS-1:0] we_ram,
    output logic                 cell_rst,
    output logic [IDX_W-1:0]     cell_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_SETUP  = 3'd3;
    localparam logic [2:0] S_STROBE = 3'd4;
    localparam logic [2:0] S_HOLD   = 3'd5;
    localparam logic [2:0] S_FINISH = 3'd6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     cell_idx_q, cell_idx_d;
    logic [3:0]           set_ram_q, set_ram_d;
    logic [NUM_CELLS-1:0] we_ram_q, we_ram_d;
    logic                 cell_rst_q, cell_rst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // abort overrides every transition, including a start seen in IDLE
    always_comb begin
        state_d    = state_q;
        cell_idx_d = cell_idx_q;
        set_ram_d  = set_ram_q;
        if (abort) begin
            state_d    = S_IDLE;
            cell_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cell_idx_d = '0;
                    state_d    = S_WAIT;
                end
                S_WAIT: begin
                    if (cfg_valid) begin
                        set_ram_d = cfg_data;
                        state_d   = S_SETUP;
                    end
                end
                S_SETUP: begin
                    state_d = S_STROBE;
                end
                S_STROBE: begin
                    state_d = S_HOLD;
                end
                S_HOLD: begin
                    if (cell_idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        cell_idx_d = cell_idx_q + IDX_W'(1);
                        state_d    = S_WAIT;
                    end
                end
                S_FINISH: begin
                    cell_idx_d = '0;
                    state_d    = S_IDLE;
                end
                default: begin
                    cell_idx_d = '0;
                    state_d    = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are precomputed from the next state so they leave a flop directly.
    always_comb begin
        we_ram_d = '0;
        if (state_d == S_STROBE) begin
            we_ram_d = NUM_CELLS'(1) << cell_idx_d;
        end
        cell_rst_d = (state_d == S_CLEAR);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cell_idx_q <= '0;
            set_ram_q  <= '0;
            we_ram_q   <= '0;
            cell_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cell_idx_q <= cell_idx_d;
            set_ram_q  <= set_ram_d;
            we_ram_q   <= we_ram_d;
            cell_rst_q <= cell_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign cfg_ready = (state_q == S_WAIT) && !abort;
    assign set_ram   = set_ram_q;
    assign we_ram    = we_ram_q;
    assign cell_rst  = cell_rst_q;
    assign cell_idx  = cell_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cell_config_loader.sv
// Self-checking bench for cell_config_loader with a 4-cell array: directed table, reset/abort corners, random loads.
// Expected timing comes from cycle arithmetic on handshake gaps; shadow cells capture set_ram on each strobe.
module tb_cell_config_loader;

    localparam int N    = 4;
    localparam int IW   = 2;
    localparam int MAXC = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [3:0]    cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [3:0]    set_ram;
    logic [N-1:0]  we_ram;
    logic          cell_rst;
    logic [IW-1:0] cell_idx;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    cell_config_loader #(.NUM_CELLS(N), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .set_ram(set_ram), .we_ram(we_ram), .cell_rst(cell_rst),
        .cell_idx(cell_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0][7:0] gap;
        int                abort_cyc;
        int                restart_cyc;
        int                exp_done_cyc;
        int                exp_strobes;
        logic [15:0]       exp_cells;
    } vec_t;

    vec_t       vecs[5];
    logic [3:0] words[N];
    logic [3:0] shadow[N];
    logic [3:0] model_cells[N];
    logic [3:0] prev_set;
    int         gap_m[N];
    int         abort_m;
    int         restart_m;
    logic       fixed_m;
    logic       rand_start_m;
    int         obs_done_cyc;
    int         obs_strobes;
    int         model_done_cyc;
    int         model_strobes;

    task automatic apply_stimulus(input logic s, input logic a, input logic v, input logic [3:0] d);
        start     = s;
        abort     = a;
        cfg_valid = v;
        cfg_data  = d;
    endtask

    task automatic check_output(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // One load: word k is accepted gap_m[k] cycles after its WAIT opens, so every event time follows by arithmetic.
    task automatic do_load();
        int            ws[N];
        int            acc[N];
        int            done_c, end_c, sum, last_busy;
        logic [3:0]    sd[MAXC];
        logic          vd[MAXC];
        logic          stv[MAXC];
        logic          alive, e_rst, e_busy, e_done, e_ready;
        logic [N-1:0]  e_we;
        logic [IW-1:0] e_idx;
        logic [3:0]    e_set;
        sum = 0;
        for (int k = 0; k < N; k++) begin
            ws[k]  = 2 + 4 * k + sum;
            acc[k] = ws[k] + gap_m[k];
            sum   += gap_m[k];
        end
        done_c    = acc[N-1] + 4;
        last_busy = (abort_m >= 0) ? abort_m : done_c;
        end_c     = last_busy + 2;
        for (int c = 0; c <= end_c; c++) begin
            sd[c]  = 4'($urandom_range(0, 15));
            vd[c]  = 1'($urandom_range(0, 1));
            stv[c] = (c == 0) || (c == restart_m) ||
                     (rand_start_m && c >= 1 && c <= last_busy && $urandom_range(0, 3) == 0);
        end
        for (int k = 0; k < N; k++) begin
            for (int c = ws[k]; c <= acc[k]; c++) begin
                if (fixed_m) sd[c] = words[k];
                vd[c] = (c == acc[k]);
            end
        end
        obs_strobes  = 0;
        obs_done_cyc = -1;
        e_set        = prev_set;
        for (int c = 0; c <= end_c; c++) begin
            @(posedge clk); #1;
            apply_stimulus(stv[c], (c == abort_m), vd[c], sd[c]);
            @(negedge clk);
            alive   = (abort_m < 0) || (c <= abort_m);
            e_rst   = alive && (c == 1);
            e_busy  = alive && (c >= 1) && (c <= done_c);
            e_done  = alive && (c == done_c);
            e_ready = 1'b0;
            e_we    = '0;
            e_idx   = '0;
            e_set   = prev_set;
            for (int k = 0; k < N; k++) begin
                if (alive && c >= ws[k] && c <= acc[k] + 3) e_idx = IW'(k);
                if (alive && c >= ws[k] && c <= acc[k]) e_ready = 1'b1;
                if (alive && c == acc[k] + 2) e_we[k] = 1'b1;
                if (acc[k] < c && (abort_m < 0 || acc[k] < abort_m)) e_set = sd[acc[k]];
            end
            if (e_done) e_idx = IW'(N - 1);
            if (c == abort_m) e_ready = 1'b0;
            check_output("we_ram", c, 16'(we_ram), 16'(e_we));
            check_output("set_ram", c, 16'(set_ram), 16'(e_set));
            check_output("cell_rst", c, 16'(cell_rst), 16'(e_rst));
            check_output("cell_idx", c, 16'(cell_idx), 16'(e_idx));
            check_output("busy", c, 16'(busy), 16'(e_busy));
            check_output("done", c, 16'(done), 16'(e_done));
            check_output("cfg_ready", c, 16'(cfg_ready), 16'(e_ready));
            if (cell_rst) for (int i = 0; i < N; i++) shadow[i] = 4'h0;
            for (int i = 0; i < N; i++) if (we_ram[i]) shadow[i] = set_ram;
            obs_strobes += $countones(we_ram);
            if (done) obs_done_cyc = c;
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        model_strobes  = 0;
        model_done_cyc = (abort_m < 0) ? done_c : -1;
        for (int k = 0; k < N; k++) begin
            if (abort_m < 0 || abort_m >= acc[k] + 2) begin
                model_strobes++;
                model_cells[k] = sd[acc[k]];
            end else begin
                model_cells[k] = 4'h0;
            end
        end
        prev_set = e_set;
    endtask

    task automatic check_table_row(input int r);
        check_output("row_done_cycle", r, 16'(obs_done_cyc), 16'(vecs[r].exp_done_cyc));
        check_output("row_strobes", r, 16'(obs_strobes), 16'(vecs[r].exp_strobes));
        check_output("row_cells", r, {shadow[3], shadow[2], shadow[1], shadow[0]}, vecs[r].exp_cells);
    endtask

    initial begin
        words[0] = 4'h1; words[1] = 4'h2; words[2] = 4'h3; words[3] = 4'h0;
        for (int i = 0; i < N; i++) shadow[i] = 4'h0;
        prev_set = 4'h0;
        // gap is {cell3, cell2, cell1, cell0}; cells are {c3, c2, c1, c0}
        vecs[0] = '{gap: {8'd0, 8'd0, 8'd0, 8'd0}, abort_cyc: -1, restart_cyc: -1,
                    exp_done_cyc: 18, exp_strobes: 4, exp_cells: 16'h0321};
        vecs[1] = '{gap: {8'd0, 8'd3, 8'd0, 8'd0}, abort_cyc: -1, restart_cyc: -1,
                    exp_done_cyc: 21, exp_strobes: 4, exp_cells: 16'h0321};
        vecs[2] = '{gap: {8'd0, 8'd0, 8'd0, 8'd0}, abort_cyc: 8, restart_cyc: -1,
                    exp_done_cyc: -1, exp_strobes: 2, exp_cells: 16'h0021};
        vecs[3] = '{gap: {8'd0, 8'd0, 8'd0, 8'd0}, abort_cyc: -1, restart_cyc: 6,
                    exp_done_cyc: 18, exp_strobes: 4, exp_cells: 16'h0321};
        vecs[4] = '{gap: {8'd0, 8'd0, 8'd0, 8'd0}, abort_cyc: 10, restart_cyc: -1,
                    exp_done_cyc: -1, exp_strobes: 2, exp_cells: 16'h0021};

        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_we_ram", 0, 16'(we_ram), 16'h0);
        check_output("reset_set_ram", 0, 16'(set_ram), 16'h0);
        check_output("reset_cell_rst", 0, 16'(cell_rst), 16'h0);
        check_output("reset_cell_idx", 0, 16'(cell_idx), 16'h0);
        check_output("reset_busy", 0, 16'(busy), 16'h0);
        check_output("reset_done", 0, 16'(done), 16'h0);
        check_output("reset_cfg_ready", 0, 16'(cfg_ready), 16'h0);
        rst = 1'b0;

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < N; k++) gap_m[k] = int'(vecs[r].gap[k]);
            abort_m      = vecs[r].abort_cyc;
            restart_m    = vecs[r].restart_cyc;
            fixed_m      = 1'b1;
            rand_start_m = 1'b0;
            do_load();
            check_table_row(r);
        end

        // abort and start together in IDLE: abort wins
        @(posedge clk); #1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'h5);
        @(negedge clk);
        check_output("idle_abort_ready", 0, 16'(cfg_ready), 16'h0);
        @(posedge clk); #1;
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        check_output("idle_abort_busy", 1, 16'(busy), 16'h0);
        check_output("idle_abort_cell_rst", 1, 16'(cell_rst), 16'h0);

        // asynchronous reset in the middle of cell 0's strobe
        @(posedge clk); #1;
        apply_stimulus(1'b1, 1'b0, 1'b1, 4'h9);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            apply_stimulus(1'b0, 1'b0, 1'b1, 4'h9);
        end
        @(negedge clk);
        check_output("pre_rst_we_ram", 4, 16'(we_ram), 16'h1);
        check_output("pre_rst_set_ram", 4, 16'(set_ram), 16'h9);
        #1 rst = 1'b1;
        #1;
        check_output("mid_rst_we_ram", 4, 16'(we_ram), 16'h0);
        check_output("mid_rst_busy", 4, 16'(busy), 16'h0);
        check_output("mid_rst_cell_idx", 4, 16'(cell_idx), 16'h0);
        check_output("mid_rst_set_ram", 4, 16'(set_ram), 16'h0);
        check_output("mid_rst_done", 4, 16'(done), 16'h0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0);
        #1 rst = 1'b0;
        prev_set = 4'h0;
        for (int k = 0; k < N; k++) gap_m[k] = 0;
        abort_m   = -1;
        restart_m = -1;
        do_load();
        check_table_row(0);

        // random handshake gaps, stray start pulses and occasional aborts
        for (int n = 0; n < 100; n++) begin
            int total;
            total = 0;
            for (int k = 0; k < N; k++) begin
                gap_m[k] = int'($urandom_range(0, 4));
                total   += gap_m[k];
            end
            abort_m      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 1 + 4 * N + total)) : -1;
            restart_m    = -1;
            fixed_m      = 1'b0;
            rand_start_m = 1'b1;
            do_load();
            check_output("rand_strobes", n, 16'(obs_strobes), 16'(model_strobes));
            check_output("rand_done_cycle", n, 16'(obs_done_cyc), 16'(model_done_cyc));
            check_output("rand_cells", n, {shadow[3], shadow[2], shadow[1], shadow[0]},
                         {model_cells[3], model_cells[2], model_cells[1], model_cells[0]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
